// File: rtl/buff_modport.sv
// Dual 512-byte endpoint buffer between the application and the USB packet engine.
// Optional BUFF_LEN_CLAMP_EN: clamps latched lengths to DEPTH and adds the sticky buf_in_ovf flag.
module buff_modport #(
    parameter int DEPTH = 512,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          ext_clk,
    input  logic          reset,
    input  logic [AW-1:0] buf_in_addr,
    input  logic [7:0]    buf_in_data,
    input  logic          buf_in_wren,
    output logic          buf_in_ready,
    input  logic          buf_in_commit,
    input  logic [LW-1:0] buf_in_commit_len,
    output logic          buf_in_commit_ack,
    output logic          in_pending,
    output logic [LW-1:0] in_len,
    input  logic [AW-1:0] in_rd_addr,
    output logic [7:0]    in_rd_q,
    input  logic          in_done,
    input  logic [AW-1:0] out_wr_addr,
    input  logic [7:0]    out_wr_data,
    input  logic          out_wr_en,
    input  logic          out_wr_commit,
    input  logic [LW-1:0] out_wr_len,
    input  logic [AW-1:0] buf_out_addr,
    output logic [7:0]    buf_out_q,
    output logic [LW-1:0] buf_out_len,
    output logic          buf_out_hasdata,
    input  logic          buf_out_arm,
    output logic          buf_out_arm_ack
`ifdef BUFF_LEN_CLAMP_EN
    ,
    output logic          buf_in_ovf
`endif
);

    // state    | meaning
    // IN_IDLE  | IN buffer free, application may fill and commit
    // IN_PEND  | committed IN packet held until the engine reports done
    typedef enum logic {IN_IDLE, IN_PEND} in_state_t;

    in_state_t     in_state;
    logic [7:0]    in_mem  [DEPTH];
    logic [7:0]    out_mem [DEPTH];
    logic [LW-1:0] in_len_lat;
    logic [LW-1:0] out_len_lat;

`ifdef BUFF_LEN_CLAMP_EN
    localparam logic [LW-1:0] MAX_LEN = LW'(DEPTH);
    logic in_len_over;

    always_comb begin
        in_len_over = buf_in_commit_len > MAX_LEN;
        in_len_lat  = in_len_over ? MAX_LEN : buf_in_commit_len;
        out_len_lat = (out_wr_len > MAX_LEN) ? MAX_LEN : out_wr_len;
    end
`else
    always_comb begin
        in_len_lat  = buf_in_commit_len;
        out_len_lat = out_wr_len;
    end
`endif

    // Array writes are gated by the owner flags so a held packet cannot be overwritten.
    always_ff @(posedge ext_clk) begin
        if (buf_in_wren && buf_in_ready)
            in_mem[buf_in_addr] <= buf_in_data;
        if (out_wr_en && !buf_out_hasdata)
            out_mem[out_wr_addr] <= out_wr_data;
    end

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            in_rd_q   <= '0;
            buf_out_q <= '0;
        end else begin
            in_rd_q   <= in_mem[in_rd_addr];
            buf_out_q <= out_mem[buf_out_addr];
        end
    end

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            in_state          <= IN_IDLE;
            buf_in_ready      <= 1'b1;
            in_pending        <= 1'b0;
            buf_in_commit_ack <= 1'b0;
            in_len            <= '0;
`ifdef BUFF_LEN_CLAMP_EN
            buf_in_ovf        <= 1'b0;
`endif
        end else begin
            buf_in_commit_ack <= 1'b0;
            case (in_state)
                IN_IDLE: begin
                    if (buf_in_commit) begin
                        in_state          <= IN_PEND;
                        buf_in_ready      <= 1'b0;
                        in_pending        <= 1'b1;
                        buf_in_commit_ack <= 1'b1;
                        in_len            <= in_len_lat;
`ifdef BUFF_LEN_CLAMP_EN
                        if (in_len_over)
                            buf_in_ovf <= 1'b1;
`endif
                    end
                end
                IN_PEND: begin
                    if (in_done) begin
                        in_state     <= IN_IDLE;
                        buf_in_ready <= 1'b1;
                        in_pending   <= 1'b0;
                    end
                end
                default: in_state <= IN_IDLE;
            endcase
        end
    end

    // Arm takes priority over a coinciding commit, so a commit in that cycle is dropped.
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            buf_out_hasdata <= 1'b0;
            buf_out_len     <= '0;
            buf_out_arm_ack <= 1'b0;
        end else begin
            buf_out_arm_ack <= buf_out_arm;
            if (buf_out_arm) begin
                buf_out_hasdata <= 1'b0;
            end else if (out_wr_commit && !buf_out_hasdata) begin
                buf_out_hasdata <= 1'b1;
                buf_out_len     <= out_len_lat;
            end
        end
    end

endmodule

// File: tb/tb_buff_modport.sv
// Self-checking bench for buff_modport: directed vector table, hand sequences and
// randomized traffic against a transaction-level reference model.
module tb_buff_modport;

    logic       ext_clk;
    logic       reset;
    logic [8:0] buf_in_addr;
    logic [7:0] buf_in_data;
    logic       buf_in_wren;
    logic       buf_in_ready;
    logic       buf_in_commit;
    logic [9:0] buf_in_commit_len;
    logic       buf_in_commit_ack;
    logic       in_pending;
    logic [9:0] in_len;
    logic [8:0] in_rd_addr;
    logic [7:0] in_rd_q;
    logic       in_done;
    logic [8:0] out_wr_addr;
    logic [7:0] out_wr_data;
    logic       out_wr_en;
    logic       out_wr_commit;
    logic [9:0] out_wr_len;
    logic [8:0] buf_out_addr;
    logic [7:0] buf_out_q;
    logic [9:0] buf_out_len;
    logic       buf_out_hasdata;
    logic       buf_out_arm;
    logic       buf_out_arm_ack;
`ifdef BUFF_LEN_CLAMP_EN
    logic       buf_in_ovf;
`endif

    buff_modport dut (
        .ext_clk(ext_clk), .reset(reset),
        .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
        .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
        .in_pending(in_pending), .in_len(in_len), .in_rd_addr(in_rd_addr), .in_rd_q(in_rd_q),
        .in_done(in_done), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
        .out_wr_en(out_wr_en), .out_wr_commit(out_wr_commit), .out_wr_len(out_wr_len),
        .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
        .buf_out_hasdata(buf_out_hasdata), .buf_out_arm(buf_out_arm),
        .buf_out_arm_ack(buf_out_arm_ack)
`ifdef BUFF_LEN_CLAMP_EN
        , .buf_in_ovf(buf_in_ovf)
`endif
    );

    initial ext_clk = 1'b0;
    always #5 ext_clk = ~ext_clk;

    int checks = 0;
    int failures = 0;

    // reference model: packet ownership flags, latched lengths and byte arrays
    logic [7:0] m_in  [512];
    logic [7:0] m_out [512];
    bit         m_in_v  [512];
    bit         m_out_v [512];
    bit         m_pending, m_has, m_ovf;
    logic [9:0] m_in_len, m_out_len;
    bit         e_cack, e_aack, e_rdv, e_outv;
    logic [7:0] e_rdq, e_outq;

    function automatic logic [9:0] m_clamp(input logic [9:0] l);
`ifdef BUFF_LEN_CLAMP_EN
        return (l > 10'd512) ? 10'd512 : l;
`else
        return l;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        if (reset) begin
            m_pending = 0; m_has = 0; m_ovf = 0;
            m_in_len = '0; m_out_len = '0;
            e_cack = 0; e_aack = 0;
            e_rdq = '0; e_rdv = 1; e_outq = '0; e_outv = 1;
        end else begin
            e_rdv  = m_in_v[in_rd_addr];   e_rdq  = m_in[in_rd_addr];
            e_outv = m_out_v[buf_out_addr]; e_outq = m_out[buf_out_addr];
            if (buf_in_wren && !m_pending) begin
                m_in[buf_in_addr] = buf_in_data; m_in_v[buf_in_addr] = 1;
            end
            if (out_wr_en && !m_has) begin
                m_out[out_wr_addr] = out_wr_data; m_out_v[out_wr_addr] = 1;
            end
            e_cack = buf_in_commit && !m_pending;
            if (e_cack) begin
                m_pending = 1;
                m_in_len = m_clamp(buf_in_commit_len);
                if (buf_in_commit_len > 10'd512) m_ovf = 1;
            end else if (in_done && m_pending) begin
                m_pending = 0;
            end
            e_aack = buf_out_arm;
            if (buf_out_arm) m_has = 0;
            else if (out_wr_commit && !m_has) begin
                m_has = 1;
                m_out_len = m_clamp(out_wr_len);
            end
        end
    endtask

    task automatic compare_model();
        chk("ready", buf_in_ready, !m_pending);
        chk("pending", in_pending, m_pending);
        chk("in_len", in_len, m_in_len);
        chk("commit_ack", buf_in_commit_ack, e_cack);
        chk("hasdata", buf_out_hasdata, m_has);
        chk("out_len", buf_out_len, m_out_len);
        chk("arm_ack", buf_out_arm_ack, e_aack);
        if (e_rdv)  chk("in_rd_q", in_rd_q, e_rdq);
        if (e_outv) chk("buf_out_q", buf_out_q, e_outq);
`ifdef BUFF_LEN_CLAMP_EN
        chk("ovf", buf_in_ovf, m_ovf);
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge ext_clk);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        reset = 0;
        buf_in_addr = '0; buf_in_data = '0; buf_in_wren = 0;
        buf_in_commit = 0; buf_in_commit_len = '0; in_rd_addr = '0; in_done = 0;
        out_wr_addr = '0; out_wr_data = '0; out_wr_en = 0;
        out_wr_commit = 0; out_wr_len = '0; buf_out_addr = '0; buf_out_arm = 0;
    endtask

    typedef struct {
        logic [8:0] a;  logic [7:0] d;  logic we;
        logic cm;       logic [9:0] cl; logic dn;  logic [8:0] ra;
        logic e_rdy;    logic e_pend;   logic [9:0] e_len; logic e_ack;
        logic rdchk;    logic [7:0] e_rdq;
    } in_vec_t;

    in_vec_t tbl [11];

    initial begin
        //           a    d      we cm cl  dn ra   rdy pend len ack rdchk rdq
        tbl[0]  = '{9'd0,   8'hA5, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 8'h00};
        tbl[1]  = '{9'd511, 8'h5A, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 8'h00};
        tbl[2]  = '{9'd0,   8'h00, 0, 1, 2, 0, 0,   0, 1, 2, 1, 1, 8'hA5};
        tbl[3]  = '{9'd0,   8'h00, 0, 0, 0, 0, 511, 0, 1, 2, 0, 1, 8'h5A};
        tbl[4]  = '{9'd0,   8'hFF, 1, 1, 7, 0, 0,   0, 1, 2, 0, 1, 8'hA5};
        tbl[5]  = '{9'd0,   8'h00, 0, 0, 0, 0, 0,   0, 1, 2, 0, 1, 8'hA5};
        tbl[6]  = '{9'd0,   8'h00, 0, 0, 0, 1, 0,   1, 0, 2, 0, 0, 8'h00};
        tbl[7]  = '{9'd0,   8'h00, 0, 0, 0, 1, 0,   1, 0, 2, 0, 0, 8'h00};
        tbl[8]  = '{9'd0,   8'h00, 0, 1, 0, 0, 0,   0, 1, 0, 1, 0, 8'h00};
        tbl[9]  = '{9'd0,   8'h00, 0, 1, 5, 0, 0,   0, 1, 0, 0, 0, 8'h00};
        tbl[10] = '{9'd0,   8'h00, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 8'h00};

        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        chk("rst_ready", buf_in_ready, 1);
        chk("rst_pending", in_pending, 0);
        chk("rst_in_len", in_len, 0);
        chk("rst_rd_q", in_rd_q, 0);
        chk("rst_out_q", buf_out_q, 0);
        chk("rst_hasdata", buf_out_hasdata, 0);

        for (int i = 0; i < 11; i++) begin
            idle_inputs();
            buf_in_addr = tbl[i].a; buf_in_data = tbl[i].d; buf_in_wren = tbl[i].we;
            buf_in_commit = tbl[i].cm; buf_in_commit_len = tbl[i].cl;
            in_done = tbl[i].dn; in_rd_addr = tbl[i].ra;
            tick();
            chk($sformatf("vec%0d_ready", i), buf_in_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d_pend", i), in_pending, tbl[i].e_pend);
            chk($sformatf("vec%0d_len", i), in_len, tbl[i].e_len);
            chk($sformatf("vec%0d_ack", i), buf_in_commit_ack, tbl[i].e_ack);
            if (tbl[i].rdchk) chk($sformatf("vec%0d_rdq", i), in_rd_q, tbl[i].e_rdq);
        end

        // OUT path: fill, commit, read back, overrun, arm precedence
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            out_wr_en = 1; out_wr_addr = 9'(i); out_wr_data = 8'(8'h11 * (i + 1));
            tick();
        end
        idle_inputs(); out_wr_commit = 1; out_wr_len = 10'd3; tick();
        chk("out_hasdata", buf_out_hasdata, 1);
        chk("out_len3", buf_out_len, 3);
        idle_inputs(); buf_out_addr = 9'd2; out_wr_en = 1; out_wr_addr = 9'd2; out_wr_data = 8'hEE;
        tick();
        chk("out_q_addr2", buf_out_q, 8'h33);
        idle_inputs(); out_wr_commit = 1; out_wr_len = 10'd9; tick();
        chk("overrun_len", buf_out_len, 3);
        chk("overrun_has", buf_out_hasdata, 1);
        idle_inputs(); out_wr_commit = 1; out_wr_len = 10'd9; buf_out_arm = 1; tick();
        chk("arm_wins_has", buf_out_hasdata, 0);
        chk("arm_wins_ack", buf_out_arm_ack, 1);
        chk("arm_wins_len", buf_out_len, 3);
        idle_inputs(); buf_out_addr = 9'd2; tick();
        chk("arm_ack_drop", buf_out_arm_ack, 0);
        chk("out_q_protected", buf_out_q, 8'h33);
        idle_inputs(); buf_out_arm = 1; tick();
        chk("arm_idle_ack1", buf_out_arm_ack, 1);
        tick();
        chk("arm_idle_ack2", buf_out_arm_ack, 1);
        idle_inputs(); out_wr_commit = 1; out_wr_len = 10'd0; tick();
        chk("out_zero_len_has", buf_out_hasdata, 1);
        chk("out_zero_len", buf_out_len, 0);

        // reset while both packets are held
        idle_inputs(); buf_in_commit = 1; buf_in_commit_len = 10'd4; in_rd_addr = 9'd511;
        buf_out_addr = 9'd1; tick();
        chk("pre_rst_pending", in_pending, 1);
        reset = 1; tick();
        chk("mid_rst_ready", buf_in_ready, 1);
        chk("mid_rst_pending", in_pending, 0);
        chk("mid_rst_in_len", in_len, 0);
        chk("mid_rst_rd_q", in_rd_q, 0);
        chk("mid_rst_out_q", buf_out_q, 0);
        chk("mid_rst_has", buf_out_hasdata, 0);
        chk("mid_rst_out_len", buf_out_len, 0);
        chk("mid_rst_ack", buf_in_commit_ack, 0);

`ifdef BUFF_LEN_CLAMP_EN
        idle_inputs(); buf_in_commit = 1; buf_in_commit_len = 10'd600; tick();
        chk("clamp_len", in_len, 512);
        chk("clamp_ovf", buf_in_ovf, 1);
        idle_inputs(); in_done = 1; tick();
        idle_inputs(); buf_in_commit = 1; buf_in_commit_len = 10'd3; tick();
        chk("ovf_sticky", buf_in_ovf, 1);
        chk("len_after_clamp", in_len, 3);
        idle_inputs(); out_wr_commit = 1; out_wr_len = 10'd700; tick();
        chk("out_clamp_len", buf_out_len, 512);
        idle_inputs(); reset = 1; tick();
        chk("ovf_cleared", buf_in_ovf, 0);
`endif

        // randomized traffic on a small address window so reads hit written bytes
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            if ($urandom_range(0, 99) == 0) begin
                reset = 1;
            end else begin
                buf_in_wren = ($urandom_range(0, 1) == 1);
                buf_in_addr = 9'($urandom_range(0, 15));
                buf_in_data = 8'($urandom);
                buf_in_commit = ($urandom_range(0, 9) == 0);
                buf_in_commit_len = 10'($urandom_range(0, 700));
                in_done = ($urandom_range(0, 9) == 0);
                in_rd_addr = 9'($urandom_range(0, 15));
                out_wr_en = ($urandom_range(0, 1) == 1);
                out_wr_addr = 9'($urandom_range(0, 15));
                out_wr_data = 8'($urandom);
                out_wr_len = 10'($urandom_range(0, 700));
                buf_out_addr = 9'($urandom_range(0, 15));
                case ($urandom_range(0, 9))
                    0: out_wr_commit = 1;
                    1: buf_out_arm = 1;
                    default: ;
                endcase
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buff_modport.md
# buff_modport

Dual 512-byte endpoint buffer block sitting between the application buffer interface of the USB device core and its packet engine. The IN buffer holds one application packet until the packet engine has sent it. The OUT buffer holds one received packet until the application re-arms it. Both sides use single-cycle strobe handshakes on one clock.

## Interface
Parameters:
- DEPTH, 512: bytes per buffer; address width is 9, length width is 10.

Ports (clock and reset first):
- ext_clk  in  1  sole clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- buf_in_addr  in  9  application IN write address.
- buf_in_data  in  8  application IN write data.
- buf_in_wren  in  1  IN write enable.
- buf_in_ready  out  1  IN buffer free to fill and commit.
- buf_in_commit  in  1  strobe: IN packet complete.
- buf_in_commit_len  in  10  IN packet length in bytes (0..512).
- buf_in_commit_ack  out  1  one-cycle acknowledge of an accepted commit.
- in_pending  out  1  committed IN packet awaiting transmission.
- in_len  out  10  length of the pending IN packet.
- in_rd_addr  in  9  engine IN read address.
- in_rd_q  out  8  engine IN read data.
- in_done  in  1  strobe: engine finished sending the IN packet.
- out_wr_addr  in  9  engine OUT write address.
- out_wr_data  in  8  engine OUT write data.
- out_wr_en  in  1  OUT write enable.
- out_wr_commit  in  1  strobe: received OUT packet complete.
- out_wr_len  in  10  received packet length.
- buf_out_addr  in  9  application OUT read address.
- buf_out_q  out  8  application OUT read data.
- buf_out_len  out  10  length of the held OUT packet.
- buf_out_hasdata  out  1  OUT buffer holds an unread packet; also the busy flag for the engine.
- buf_out_arm  in  1  strobe: application releases the OUT buffer.
- buf_out_arm_ack  out  1  one-cycle acknowledge of arm.
- buf_in_ovf  out  1  sticky length-overflow flag; exists only with BUFF_LEN_CLAMP_EN.

## Operation
- **Memories:** two 512x8 arrays (IN, OUT), one write port and one registered read port each. Contents are not reset.
- **IN idle (buf_in_ready=1):** buf_in_wren writes buf_in_data to buf_in_addr. Writes while ready=0 are ignored, which protects the committed packet.
- **IN commit:** buf_in_commit while ready=1 latches buf_in_commit_len into in_len, clears ready, sets in_pending, and pulses buf_in_commit_ack. A commit while ready=0 is ignored and produces no ack.
- **IN done:** in_done while in_pending=1 clears in_pending and sets ready. in_done while not pending is ignored. Commit and done cannot both be effective in one cycle.
- **OUT fill:** out_wr_en writes the OUT array only while buf_out_hasdata=0.
- **OUT commit:** out_wr_commit while hasdata=0 sets hasdata and latches buf_out_len. While hasdata=1 it is ignored; the packet is dropped.
- **OUT arm:** buf_out_arm pulses buf_out_arm_ack and clears hasdata. This happens even if hasdata was already 0. If arm and out_wr_commit coincide while hasdata=1, arm wins: hasdata is cleared and the commit is dropped.
- A zero-length commit is legal on both paths.

## Timing
- **Reset values:** buf_in_ready=1, buf_in_commit_ack=0, in_pending=0, in_len=0, in_rd_q=0, buf_out_q=0, buf_out_len=0, buf_out_hasdata=0, buf_out_arm_ack=0, buf_in_ovf=0.
- **Read latency:** one cycle. Address at edge N gives data valid after edge N+1.
- **Read-during-write, same address:** returns old data.
- **Strobe responses:** commit_ack, arm_ack, ready/pending and hasdata all update on the edge that samples the strobe, so each is visible the cycle after the strobe. Acks last exactly one cycle.
- **Held strobes:** a strobe held for several cycles acts once, because the state change blocks re-acceptance. The exception is arm, which acks every cycle it is high.
- **Reset mid-operation:** all state returns to the reset values on the next edge. Any pending packet is discarded.

## Configuration
- **BUFF_LEN_CLAMP_EN defined:** buf_in_commit_len or out_wr_len above 512 is clamped to 512 when latched. An IN clamp sets sticky buf_in_ovf, which is cleared only by reset.
- **Macro absent:** lengths are latched unmodified and the buf_in_ovf port does not exist.

## Test plan
- **IN path:** reset; write 0xA5 to address 0 and 0x5A to address 511; commit len=2 -> ack pulse one cycle, ready=0, in_pending=1, in_len=2; read address 511 -> in_rd_q=0x5A one cycle later; in_done -> ready=1.
- **IN protection:** while pending, write 0xFF to address 0 and commit len=7 -> no ack, in_len stays 2, address 0 still reads 0xA5.
- **OUT path:** engine writes 3 bytes 0x11/0x22/0x33 and commits len=3 -> hasdata=1, buf_out_len=3; application reads address 2 -> 0x33; arm -> arm_ack pulse, hasdata=0.
- **OUT overrun:** second out_wr_commit (len=9) while hasdata=1 -> ignored, buf_out_len stays 3; arm together with that commit -> hasdata=0.
- **Reset mid-packet:** reset while in_pending=1 and hasdata=1 -> all outputs at their reset values next cycle.
- **BUFF_LEN_CLAMP_EN:** commit len=600 -> in_len=512, buf_in_ovf=1 until reset.
